// File: rtl/adder_cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_cla_pkg
//  Description : Shared widths and 4-wide lookahead helper functions for the
//                32-bit two-level carry-lookahead adder.
//                BW_DATA : total operand width
//                BW_BLK  : width of one level-1 lookahead block
//                N_BLK   : number of level-1 blocks
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_cla_pkg;

  localparam int BW_DATA = 32;
  localparam int BW_BLK  = 4;
  localparam int N_BLK   = BW_DATA / BW_BLK;

  // Carries 1..4 of a 4-wide lookahead cell, every term written out in
  // sum-of-products form so no carry depends on another carry.
  // Bit [i] of the result is the carry into position i+1.
  function automatic logic [3:0] cla4_carry(input logic [3:0] p,
                                            input logic [3:0] g,
                                            input logic       ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group propagate: the group passes its carry-in straight through.
  function automatic logic grp_p(input logic [3:0] p);
    return &p;
  endfunction

  // Group generate: the group produces a carry regardless of carry-in.
  function automatic logic grp_g(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_cla4.sv
`default_nettype none
// ============================================================================
//  Module      : adder_cla4
//  Description : 4-bit carry-lookahead block. Computes its internal carries
//                directly from its block carry-in and exports block
//                propagate/generate for the second lookahead level.
//  Ports       : a, b  (in, 4)  operand slices
//                cin   (in, 1)  block carry-in
//                s     (out,4)  sum slice
//                P     (out,1)  block propagate
//                G     (out,1)  block generate
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_cla4
  import adder_cla_pkg::*;
(
  input  logic [BW_BLK-1:0] a,
  input  logic [BW_BLK-1:0] b,
  input  logic              cin,
  output logic [BW_BLK-1:0] s,
  output logic              P,
  output logic              G
);

  logic [BW_BLK-1:0] w_p;
  logic [BW_BLK-1:0] w_g;
  logic [BW_BLK-1:0] w_c_hi;  // carries into bits 1..4
  logic [BW_BLK-1:0] w_c;     // carries into bits 0..3

  assign w_p    = a ^ b;
  assign w_g    = a & b;
  assign w_c_hi = cla4_carry(w_p, w_g, cin);
  assign w_c    = {w_c_hi[2:0], cin};

  assign s = w_p ^ w_c;
  assign P = grp_p(w_p);
  assign G = grp_g(w_p, w_g);

  // Block carry-out is regenerated at level 2 from P/G; the local copy is
  // only used internally.
  logic w_unused_cout;
  assign w_unused_cout = w_c_hi[3];

endmodule
`default_nettype wire

// File: rtl/adder_cla_32.sv
`default_nettype none
// ============================================================================
//  Module      : adder_cla_32
//  Description : 32-bit two-level carry-lookahead adder,
//                {o_Cout, o_S} = i_A + i_B + i_Cin.
//                Level 1: eight adder_cla4 blocks.
//                Level 2: two 4-block lookahead groups; the upper group's
//                carry-in comes from the lower group's P/G and i_Cin.
//  Macro       : ADDER_CLA_32_OREG_EN - when defined, outputs are registered
//                on rising i_clk with asynchronous active-high i_rst clearing
//                them to zero. When undefined the adder is combinational and
//                i_clk/i_rst are unused.
//  Ports       : i_clk  (in, 1)   clock for the optional output register
//                i_rst  (in, 1)   async active-high reset of that register
//                i_A    (in, 32)  addend A
//                i_B    (in, 32)  addend B
//                i_Cin  (in, 1)   carry into bit 0
//                o_S    (out,32)  sum
//                o_Cout (out,1)   carry out of bit 31
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_cla_32
  import adder_cla_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BW_DATA-1:0] i_A,
  input  logic [BW_DATA-1:0] i_B,
  input  logic               i_Cin,
  output logic [BW_DATA-1:0] o_S,
  output logic               o_Cout
);

  logic [N_BLK-1:0]   w_blk_p;
  logic [N_BLK-1:0]   w_blk_g;
  logic [N_BLK-1:0]   w_blk_cin;
  logic [BW_DATA-1:0] w_sum;

  logic [3:0] w_lo_c;     // carries into blocks 1..4
  logic [3:0] w_hi_c;     // carries into blocks 5..8 (block 8 = carry-out)
  logic       w_lo_gp;
  logic       w_lo_gg;
  logic       w_hi_cin;

  // --------------------------------------------------------------------------
  // Level 1: 4-bit lookahead blocks
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < N_BLK; k++) begin : g_blk
      adder_cla4 u_cla4 (
        .a   (i_A[k*BW_BLK +: BW_BLK]),
        .b   (i_B[k*BW_BLK +: BW_BLK]),
        .cin (w_blk_cin[k]),
        .s   (w_sum[k*BW_BLK +: BW_BLK]),
        .P   (w_blk_p[k]),
        .G   (w_blk_g[k])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Level 2: block-carry lookahead in two groups of four blocks
  // --------------------------------------------------------------------------
  assign w_lo_c   = cla4_carry(w_blk_p[3:0], w_blk_g[3:0], i_Cin);
  assign w_lo_gp  = grp_p(w_blk_p[3:0]);
  assign w_lo_gg  = grp_g(w_blk_p[3:0], w_blk_g[3:0]);
  // Upper group carry-in from the lower group's P/G, not from w_lo_c[3].
  assign w_hi_cin = w_lo_gg | (w_lo_gp & i_Cin);
  assign w_hi_c   = cla4_carry(w_blk_p[7:4], w_blk_g[7:4], w_hi_cin);

  assign w_blk_cin = {w_hi_c[2:0], w_hi_cin, w_lo_c[2:0], i_Cin};

  // Lower-group carry into block 4 duplicates w_hi_cin.
  logic w_unused_lo_c3;
  assign w_unused_lo_c3 = w_lo_c[3];

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
`ifdef ADDER_CLA_32_OREG_EN
  logic [BW_DATA-1:0] r_s;
  logic               r_cout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_hi_c[3];
    end
  end

  assign o_S    = r_s;
  assign o_Cout = r_cout;
`else
  assign o_S    = w_sum;
  assign o_Cout = w_hi_c[3];

  // Clock and reset exist only for interface compatibility in this build.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = i_clk ^ i_rst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_cla_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_cla_32
//  Description : Self-checking bench for adder_cla_32. Follows the
//                ADDER_CLA_32_OREG_EN build choice of the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_cla_32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] s;
  logic        cout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  adder_cla_32 dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_A    (a),
    .i_B    (b),
    .i_Cin  (cin),
    .o_S    (s),
    .o_Cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic.
  function automatic logic [32:0] ref_sum(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  // Drive one vector and wait until its result should be visible.
  task automatic apply(input logic [31:0] x, input logic [31:0] y,
                       input logic c);
`ifdef ADDER_CLA_32_OREG_EN
    @(negedge clk);
    a = x; b = y; cin = c;
    @(posedge clk);
    #1;
`else
    a = x; b = y; cin = c;
    #1;
`endif
  endtask

  task automatic test_reset();
    logic [32:0] exp;
    rst = 1'b1;
    a = 32'h0000_0005; b = 32'h0000_0007; cin = 1'b0;
    #1;
`ifdef ADDER_CLA_32_OREG_EN
    exp = 33'd0;
    @(posedge clk); #1;  // held in reset across an edge
`else
    exp = ref_sum(a, b, cin);
`endif
    total_cnt++;
    if ({cout, s} !== exp)
      $display("FAIL reset_state: got cout=%b s=%h, want cout=%b s=%h",
               cout, s, exp[32], exp[31:0]);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                            32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] tb [5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001,
                            32'hFFFF_FFFF, 32'h9ABC_DEF0};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [32:0] te [5] = '{33'h0_0000_0000, 33'h1_0000_0000, 33'h0_8000_0000,
                            33'h1_FFFF_FFFF, 33'h0_ACF1_3568};
    for (int i = 0; i < 5; i++) begin
      apply(ta[i], tb[i], tc[i]);
      total_cnt++;
      if ({cout, s} !== te[i])
        $display("FAIL directed_%0d: got cout=%b s=%h, want cout=%b s=%h",
                 i, cout, s, te[i][32], te[i][31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic        c;
    logic [32:0] exp;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      c = 1'($urandom_range(0, 1));
      case (i % 3)
        0: y = $urandom;
        1: y = ~x;                        // long propagate runs
        default: y = ~x ^ (32'd1 << $urandom_range(0, 31));
      endcase
      exp = ref_sum(x, y, c);
      apply(x, y, c);
      total_cnt++;
      if ({cout, s} !== exp)
        $display("FAIL random_%0d: a=%h b=%h cin=%b got cout=%b s=%h, want cout=%b s=%h",
                 i, x, y, c, cout, s, exp[32], exp[31:0]);
      else pass_cnt++;
    end
  endtask

  // Single carry injected at each block boundary: exercises every level-2 carry.
  task automatic test_block_carries();
    logic [31:0] x;
    logic [32:0] exp;
    for (int k = 0; k < 8; k++) begin
      x = (32'hFFFF_FFFF << (4 * k));
      exp = ref_sum(x, 32'd1 << (4 * k), 1'b0);
      apply(x, 32'd1 << (4 * k), 1'b0);
      total_cnt++;
      if ({cout, s} !== exp)
        $display("FAIL blk_carry_%0d: got cout=%b s=%h, want cout=%b s=%h",
                 k, cout, s, exp[32], exp[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic [32:0] exp;
    apply($urandom, $urandom, 1'b1);
`ifdef ADDER_CLA_32_OREG_EN
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({cout, s} !== 33'd0)
      $display("FAIL mid_reset_async: got cout=%b s=%h, want cout=0 s=00000000",
               cout, s);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({cout, s} !== 33'd0)
      $display("FAIL mid_reset_hold: got cout=%b s=%h, want cout=0 s=00000000",
               cout, s);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    #1;
    total_cnt++;
    if ({cout, s} !== 33'd0)
      $display("FAIL mid_reset_pre_edge: got cout=%b s=%h, want cout=0 s=00000000",
               cout, s);
    else pass_cnt++;
    @(posedge clk); #1;
`else
    rst = 1'b1;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    #1;
    rst = 1'b0;
`endif
    exp = ref_sum(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    total_cnt++;
    if ({cout, s} !== exp)
      $display("FAIL mid_reset_result: got cout=%b s=%h, want cout=%b s=%h",
               cout, s, exp[32], exp[31:0]);
    else pass_cnt++;
  endtask

  // Streams a new vector every cycle; each result is checked one cycle later
  // (registered) or immediately (combinational) from a queue of expectations.
  task automatic test_back_to_back();
    logic [32:0] q[$];
    logic [31:0] x, y;
    logic        c;
    logic [32:0] exp;
    for (int i = 0; i < 20; i++) begin
      x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
      q.push_back(ref_sum(x, y, c));
      apply(x, y, c);
      exp = q.pop_front();
      total_cnt++;
      if ({cout, s} !== exp)
        $display("FAIL b2b_%0d: got cout=%b s=%h, want cout=%b s=%h",
                 i, cout, s, exp[32], exp[31:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_directed();
    test_block_carries();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
